receive_hello: RTL and testbench

// - Receive-side counterpart of the "Hello World!" UART transmitter: consumes bytes from the uart component's RX outputs.
// - Detects the 12-byte greeting "Hello World!" in the incoming stream.
// - Counts complete greetings, reports match progress, and drives a stretched LED on every match.
// - Sits between uart0 (received/rx_byte/recv_error) and board LEDs in the loopback/exploration top level.

---
 rtl/receive_hello_pkg.sv | 38 +++
 rtl/receive_hello_pulse_stretch.sv | 28 ++
 rtl/receive_hello.sv | 108 ++++++++++
 tb/tb_receive_hello.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/receive_hello_pkg.sv
// Shared definitions for the "Hello World!" receiver: the greeting string,
// its length and the matcher state encoding.
package receive_hello_pkg;

   // Number of characters in the greeting, including the trailing '!'
   localparam int GREETING_SIZE = 12;

   // Index of the final greeting character
   localparam logic [3:0] LAST_IDX = 4'(GREETING_SIZE - 1);

   // IDLE means nothing matched yet; HUNT means a partial greeting is in progress
   typedef enum logic {
      IDLE = 1'b0,
      HUNT = 1'b1
   } hello_state_t;

   // Greeting character at position i; the transmitter uses the same table
   function automatic logic [7:0] greeting_char(input logic [3:0] i);
      logic [7:0] c;
      case (i)
         4'd0:    c = "H";
         4'd1:    c = "e";
         4'd2:    c = "l";
         4'd3:    c = "l";
         4'd4:    c = "o";
         4'd5:    c = " ";
         4'd6:    c = "W";
         4'd7:    c = "o";
         4'd8:    c = "r";
         4'd9:    c = "l";
         4'd10:   c = "d";
         4'd11:   c = "!";
         default: c = 8'h00;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/receive_hello_pulse_stretch.sv
// Stretches a single-cycle trigger into a CYCLES-long high level; a new
// trigger while already high restarts the full interval.
module pulse_stretch #(
   parameter int WIDTH  = 21,
   parameter int CYCLES = 1665000
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   output logic out
);

   logic [WIDTH-1:0] cnt;

   // Load on trigger, otherwise count down to zero and hold there
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (trig) begin
         cnt <= WIDTH'(CYCLES);
      end else if (cnt != '0) begin
         cnt <= cnt - WIDTH'(1);
      end
   end

   assign out = (cnt != '0);

endmodule

// File: rtl/receive_hello.sv
// Watches the UART receive strobes for the "Hello World!" greeting, counts
// complete greetings, reports progress, and lights an LED after each match.
module receive_hello
   import receive_hello_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 34690,
   parameter int LED_CYCLES     = 1665000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        received,
   input  logic [7:0]  rx_byte,
   input  logic        recv_error,
   output logic        match,
   output logic        mismatch,
   output logic        timeout,
   output logic [3:0]  progress,
   output logic [15:0] match_count,
   output logic        match_led
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int LW = $clog2(LED_CYCLES + 1);

   hello_state_t state;

   logic [TW-1:0] idle_cnt;
   logic [TW-1:0] idle_cnt_next;
   logic [3:0]    progress_next;
   logic [15:0]   match_count_next;
   logic          match_next;
   logic          mismatch_next;
   logic          timeout_next;

   // Register the progress counter (which doubles as the FSM state) and all outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         progress    <= '0;
         idle_cnt    <= '0;
         match_count <= '0;
         match       <= 1'b0;
         mismatch    <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         progress    <= progress_next;
         idle_cnt    <= idle_cnt_next;
         match_count <= match_count_next;
         match       <= match_next;
         mismatch    <= mismatch_next;
         timeout     <= timeout_next;
      end
   end

   // Next-state logic: framing errors beat received bytes, which beat the timeout
   always_comb begin
      state            = (progress == 4'd0) ? IDLE : HUNT;
      progress_next    = progress;
      idle_cnt_next    = idle_cnt;
      match_count_next = match_count;
      match_next       = 1'b0;
      mismatch_next    = 1'b0;
      timeout_next     = 1'b0;

      if (recv_error) begin
         progress_next = 4'd0;
         mismatch_next = (state == HUNT);
         idle_cnt_next = '0;
      end else if (received) begin
         idle_cnt_next = '0;
         if (rx_byte == greeting_char(progress)) begin
            if (progress == LAST_IDX) begin
               progress_next = 4'd0;
               match_next    = 1'b1;
               if (match_count != 16'hFFFF) begin
                  match_count_next = match_count + 16'd1;
               end
            end else begin
               progress_next = progress + 4'd1;
            end
         end else if (state == HUNT) begin
            mismatch_next = 1'b1;
            progress_next = (rx_byte == greeting_char(4'd0)) ? 4'd1 : 4'd0;
         end
      end else if (state == HUNT) begin
         if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            progress_next = 4'd0;
            timeout_next  = 1'b1;
         end else begin
            idle_cnt_next = idle_cnt + TW'(1);
         end
      end

      if (progress_next == 4'd0) begin
         idle_cnt_next = '0;
      end
   end

   pulse_stretch #(
      .WIDTH  (LW),
      .CYCLES (LED_CYCLES)
   ) u_led_stretch (
      .clk  (clk),
      .rst  (rst),
      .trig (match_next),
      .out  (match_led)
   );

endmodule

// File: tb/tb_receive_hello.sv
// Directed self-checking bench for receive_hello with shortened timeout and
// LED intervals so every scenario finishes in a few hundred clocks.
module tb_receive_hello;

   localparam int TIMEOUT_CYCLES = 40;
   localparam int LED_CYCLES     = 20;
   localparam int GAP            = 3;

   logic        clk;
   logic        rst;
   logic        received;
   logic [7:0]  rx_byte;
   logic        recv_error;
   logic        match;
   logic        mismatch;
   logic        timeout;
   logic [3:0]  progress;
   logic [15:0] match_count;
   logic        match_led;

   int evaluated;
   int failures;
   int match_seen;
   int mismatch_seen;
   int timeout_seen;

   receive_hello #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .LED_CYCLES     (LED_CYCLES)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .received    (received),
      .rx_byte     (rx_byte),
      .recv_error  (recv_error),
      .match       (match),
      .mismatch    (mismatch),
      .timeout     (timeout),
      .progress    (progress),
      .match_count (match_count),
      .match_led   (match_led)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Tally every pulse shortly after each active edge
   initial begin
      match_seen    = 0;
      mismatch_seen = 0;
      timeout_seen  = 0;
      forever begin
         @(posedge clk);
         #1;
         if (match)    match_seen++;
         if (mismatch) mismatch_seen++;
         if (timeout)  timeout_seen++;
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      evaluated++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One strobe for one clock; on return the registered results are visible
   task automatic apply_stimulus(input logic [7:0] b, input logic err);
      @(negedge clk);
      received   = 1'b1;
      rx_byte    = b;
      recv_error = err;
      @(negedge clk);
      received   = 1'b0;
      recv_error = 1'b0;
   endtask

   task automatic send_string(input string s);
      for (int i = 0; i < s.len(); i++) begin
         apply_stimulus(s[i], 1'b0);
         idle(GAP);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   initial begin
      string greeting;
      int    m0;
      int    mm0;
      int    t0;

      greeting   = "Hello World!";
      evaluated  = 0;
      failures   = 0;
      rst        = 1'b0;
      received   = 1'b0;
      rx_byte    = 8'h00;
      recv_error = 1'b0;

      // Reset values
      do_reset();
      check_output("reset_match", 32'(match), 32'd0);
      check_output("reset_mismatch", 32'(mismatch), 32'd0);
      check_output("reset_timeout", 32'(timeout), 32'd0);
      check_output("reset_progress", 32'(progress), 32'd0);
      check_output("reset_count", 32'(match_count), 32'd0);
      check_output("reset_led", 32'(match_led), 32'd0);

      // Single clean greeting with progress tracked byte by byte
      m0 = match_seen;
      for (int i = 0; i < 11; i++) begin
         apply_stimulus(greeting[i], 1'b0);
         check_output($sformatf("progress_%0d", i + 1), 32'(progress), 32'(i + 1));
         idle(GAP);
      end
      apply_stimulus(greeting[11], 1'b0);
      check_output("greet_match_pulse", 32'(match), 32'd1);
      check_output("greet_progress_0", 32'(progress), 32'd0);
      check_output("greet_count", 32'(match_count), 32'd1);
      check_output("greet_led_on", 32'(match_led), 32'd1);
      idle(LED_CYCLES - 1);
      check_output("greet_led_last", 32'(match_led), 32'd1);
      check_output("greet_match_once", 32'(match_seen - m0), 32'd1);
      idle(1);
      check_output("greet_led_off", 32'(match_led), 32'd0);

      // Restart on a second 'H' inside a partial match
      do_reset();
      m0  = match_seen;
      mm0 = mismatch_seen;
      send_string("He");
      apply_stimulus("H", 1'b0);
      check_output("restart_mismatch", 32'(mismatch), 32'd1);
      check_output("restart_progress", 32'(progress), 32'd1);
      idle(GAP);
      send_string("ello World!");
      check_output("restart_count", 32'(match_count), 32'd1);
      check_output("restart_matches", 32'(match_seen - m0), 32'd1);
      check_output("restart_mismatches", 32'(mismatch_seen - mm0), 32'd1);

      // Partial match abandoned by the inter-byte timeout
      do_reset();
      m0 = match_seen;
      t0 = timeout_seen;
      send_string("Hello");
      check_output("to_progress_5", 32'(progress), 32'd5);
      idle(TIMEOUT_CYCLES + 5);
      check_output("to_pulses", 32'(timeout_seen - t0), 32'd1);
      check_output("to_progress_0", 32'(progress), 32'd0);
      send_string("World!");
      check_output("to_no_match", 32'(match_seen - m0), 32'd0);
      check_output("to_count", 32'(match_count), 32'd0);

      // Framing error coincident with a received byte
      do_reset();
      m0  = match_seen;
      mm0 = mismatch_seen;
      send_string("Hel");
      apply_stimulus("l", 1'b1);
      check_output("err_progress", 32'(progress), 32'd0);
      check_output("err_mismatch", 32'(mismatch), 32'd1);
      idle(GAP);
      send_string(greeting);
      check_output("err_count", 32'(match_count), 32'd1);
      check_output("err_mismatches", 32'(mismatch_seen - mm0), 32'd1);

      // Match counter saturation
      do_reset();
      @(negedge clk);
      force dut.match_count = 16'hFFFE;
      @(negedge clk);
      release dut.match_count;
      idle(1);
      check_output("sat_preload", 32'(match_count), 32'hFFFE);
      m0 = match_seen;
      send_string(greeting);
      check_output("sat_first", 32'(match_count), 32'hFFFF);
      send_string(greeting);
      send_string(greeting);
      check_output("sat_hold", 32'(match_count), 32'hFFFF);
      check_output("sat_matches", 32'(match_seen - m0), 32'd3);

      // Back-to-back: a match immediately followed by 'H' gives progress 1
      apply_stimulus("H", 1'b0);
      check_output("b2b_progress", 32'(progress), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
      $finish;
   end

endmodule
